stream_merge_arbiter: RTL and testbench

STREAM_MERGE_ARBITER -- requirements
Module: stream_merge_arbiter

---
 rtl/stream_merge_arbiter_pkg.sv | 26 ++
 rtl/stream_out_reg.sv | 46 ++++
 rtl/stream_merge_arbiter.sv | 170 +++++++++++++++++
 tb/tb_stream_merge_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_merge_arbiter_pkg.sv
// Shared types for the two-stream merge arbiter: FSM states and the stream element.
package stream_merge_arbiter_pkg;

   localparam int unsigned ELEM_DATA_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_EMIT_EOS = 3'd2,
      ST_WAIT_EOS = 3'd3,
      ST_CTRL     = 3'd4
   } state_e;

   typedef struct packed {
      logic [ELEM_DATA_W-1:0] field0;
      logic                   field1;
   } elem_t;

   function automatic elem_t make_elem(input logic [ELEM_DATA_W-1:0] f0, input logic f1);
      elem_t e;
      e.field0 = f0;
      e.field1 = f1;
      return e;
   endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output buffer; holds its contents while the consumer stalls.
module stream_out_reg
   import stream_merge_arbiter_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_valid,
   input  elem_t load_elem,
   input  logic  out_ready,
   output logic  out_valid,
   output elem_t out_elem,
   output logic  slot_free
);
   logic  valid_q, valid_d;
   elem_t elem_q, elem_d;

   // Next-state: a load wins, a drain clears valid, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      elem_d  = elem_q;
      if (load_valid) begin
         valid_d = 1'b1;
         elem_d  = load_elem;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Buffer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         elem_q  <= '0;
      end else begin
         valid_q <= valid_d;
         elem_q  <= elem_d;
      end
   end

   assign out_valid = valid_q;
   assign out_elem  = elem_q;
   assign slot_free = ~valid_q | out_ready;

endmodule

// File: rtl/stream_merge_arbiter.sv
// Merges two EOS-terminated streams round-robin into one, then emits one EOS and a completion token.
module stream_merge_arbiter
   import stream_merge_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ELEM_DATA_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inCtrl_valid,
   output logic                  inCtrl_ready,
   input  logic                  in0_valid,
   output logic                  in0_ready,
   input  logic [DATA_WIDTH-1:0] in0_data_field0,
   input  logic                  in0_data_field1,
   input  logic                  in1_valid,
   output logic                  in1_ready,
   input  logic [DATA_WIDTH-1:0] in1_data_field0,
   input  logic                  in1_data_field1,
   output logic                  out0_valid,
   input  logic                  out0_ready,
   output logic [DATA_WIDTH-1:0] out0_data_field0,
   output logic                  out0_data_field1,
   output logic                  outCtrl_valid,
   input  logic                  outCtrl_ready
);
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n_s;
   state_e     state_q, state_d;
   logic [1:0] eos_seen_q, eos_seen_d;
   logic       ptr_q, ptr_d;
   logic       ctrl_valid_q, ctrl_valid_d;
   logic [1:0] elig_s;
   logic       grant_valid_s, grant_s, take_s, slot_free_s, out_valid_s, load_valid_s;
   elem_t      sel_elem_s, load_elem_s, out_elem_s;

   // Reset asserts immediately but releases two clocks later.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end
   assign rst_n_s = rst_sync_q[1];

   // Arbitration: pointer input first, otherwise the other eligible input.
   always_comb begin
      elig_s        = {in1_valid & ~eos_seen_q[1], in0_valid & ~eos_seen_q[0]};
      grant_valid_s = 1'b0;
      grant_s       = ptr_q;
      if (elig_s[ptr_q]) begin
         grant_valid_s = 1'b1;
         grant_s       = ptr_q;
      end else if (elig_s[~ptr_q]) begin
         grant_valid_s = 1'b1;
         grant_s       = ~ptr_q;
      end else begin
         grant_valid_s = 1'b0;
         grant_s       = ptr_q;
      end
      if (grant_s) begin
         sel_elem_s = make_elem(ELEM_DATA_W'(in1_data_field0), in1_data_field1);
      end else begin
         sel_elem_s = make_elem(ELEM_DATA_W'(in0_data_field0), in0_data_field1);
      end
   end

   assign take_s       = (state_q == ST_RUN) & slot_free_s & grant_valid_s;
   assign in0_ready    = take_s & ~grant_s;
   assign in1_ready    = take_s & grant_s;
   assign inCtrl_ready = (state_q == ST_IDLE) & rst_n_s;

   // FSM next-state and output-register load control.
   always_comb begin
      state_d      = state_q;
      eos_seen_d   = eos_seen_q;
      ptr_d        = ptr_q;
      load_valid_s = 1'b0;
      load_elem_s  = '0;
      case (state_q)
         ST_IDLE: begin
            if (inCtrl_valid & inCtrl_ready) begin
               state_d    = ST_RUN;
               eos_seen_d = 2'b00;
               ptr_d      = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (take_s) begin
               ptr_d = ~grant_s;
               if (sel_elem_s.field1) begin
                  eos_seen_d[grant_s] = 1'b1;
               end else begin
                  load_valid_s = 1'b1;
                  load_elem_s  = make_elem(sel_elem_s.field0, 1'b0);
               end
            end else begin
               ptr_d = ptr_q;
            end
            if (eos_seen_q == 2'b11) begin
               state_d = ST_EMIT_EOS;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_EMIT_EOS: begin
            if (slot_free_s) begin
               load_valid_s = 1'b1;
               load_elem_s  = make_elem({ELEM_DATA_W{1'b0}}, 1'b1);
               state_d      = ST_WAIT_EOS;
            end else begin
               state_d = ST_EMIT_EOS;
            end
         end
         ST_WAIT_EOS: begin
            if (out_valid_s & out0_ready) begin
               state_d = ST_CTRL;
            end else begin
               state_d = ST_WAIT_EOS;
            end
         end
         ST_CTRL: begin
            if (outCtrl_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CTRL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ctrl_valid_d = (state_d == ST_CTRL);
   end

   // Control state registers.
   always_ff @(posedge clock or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q      <= ST_IDLE;
         eos_seen_q   <= 2'b00;
         ptr_q        <= 1'b0;
         ctrl_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         eos_seen_q   <= eos_seen_d;
         ptr_q        <= ptr_d;
         ctrl_valid_q <= ctrl_valid_d;
      end
   end

   stream_out_reg u_out_reg (
      .clk        (clock),
      .rst_n      (rst_n_s),
      .load_valid (load_valid_s),
      .load_elem  (load_elem_s),
      .out_ready  (out0_ready),
      .out_valid  (out_valid_s),
      .out_elem   (out_elem_s),
      .slot_free  (slot_free_s)
   );

   assign out0_valid       = out_valid_s;
   assign out0_data_field0 = DATA_WIDTH'(out_elem_s.field0);
   assign out0_data_field1 = out_elem_s.field1;
   assign outCtrl_valid    = ctrl_valid_q;

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Directed and randomized bench for stream_merge_arbiter with a per-stream scoreboard.
module tb_stream_merge_arbiter;
   localparam int DW = 64;
   localparam int W1 = DW + 1;
   localparam logic [DW:0] EOS = {1'b1, {DW{1'b0}}};

   logic clock = 1'b0;
   logic reset;
   logic inCtrl_valid, inCtrl_ready;
   logic in0_valid, in0_ready, in0_data_field1;
   logic in1_valid, in1_ready, in1_data_field1;
   logic [DW-1:0] in0_data_field0, in1_data_field0, out0_data_field0;
   logic out0_valid, out0_ready, out0_data_field1;
   logic outCtrl_valid, outCtrl_ready;

   always #5 clock = ~clock;

   stream_merge_arbiter #(.DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset),
      .inCtrl_valid(inCtrl_valid), .inCtrl_ready(inCtrl_ready),
      .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in0_data_field0(in0_data_field0), .in0_data_field1(in0_data_field1),
      .in1_valid(in1_valid), .in1_ready(in1_ready),
      .in1_data_field0(in1_data_field0), .in1_data_field1(in1_data_field1),
      .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out0_data_field0(out0_data_field0), .out0_data_field1(out0_data_field1),
      .outCtrl_valid(outCtrl_valid), .outCtrl_ready(outCtrl_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DW:0] src0[$], src1[$];
   logic [DW-1:0] q0[$], q1[$];
   logic [DW:0] out_log[$];
   int out_cyc[$];
   int i0 = 0, i1 = 0;
   logic eos0_acc = 1'b0, eos1_acc = 1'b0, eos_out_seen = 1'b0, run_active = 1'b0;
   int ctrl_cnt = 0, start_cnt = 0, eos_cyc = 0, ctrl_rise_cyc = 0;
   logic want_ctrl = 1'b0, rand_valid = 1'b0, rand_octrl = 1'b0;
   int ready_mode = 1;
   logic prev_hold = 1'b0, prev_octrl = 1'b0;
   logic [DW:0] prev_out = '0;

   function automatic logic [DW:0] mk(input logic [DW-1:0] v);
      return {1'b0, v};
   endfunction

   task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      inCtrl_valid = want_ctrl;
      if (i0 < src0.size()) begin
         in0_valid = !rand_valid || ($urandom_range(3) != 0);
         {in0_data_field1, in0_data_field0} = src0[i0];
      end else begin
         in0_valid = 1'b0;
         {in0_data_field1, in0_data_field0} = '0;
      end
      if (i1 < src1.size()) begin
         in1_valid = !rand_valid || ($urandom_range(3) != 0);
         {in1_data_field1, in1_data_field0} = src1[i1];
      end else begin
         in1_valid = 1'b0;
         {in1_data_field1, in1_data_field0} = '0;
      end
      out0_ready    = (ready_mode == 2) ? ($urandom_range(3) != 0) : (ready_mode == 1);
      outCtrl_ready = rand_octrl ? ($urandom_range(1) == 1) : 1'b1;
   endtask

   // Observes the handshakes the next rising edge will complete.
   task automatic observe();
      logic [DW:0] o;
      logic hit;
      o = {out0_data_field1, out0_data_field0};
      check("ready_onehot", W1'(in0_ready & in1_ready), W1'(1'b0));
      if (eos0_acc) check("in0_ready_after_eos", W1'(in0_ready), W1'(1'b0));
      if (eos1_acc) check("in1_ready_after_eos", W1'(in1_ready), W1'(1'b0));
      if (prev_hold) begin
         check("out_hold_valid", W1'(out0_valid), W1'(1'b1));
         check("out_hold_data", o, prev_out);
      end
      prev_hold = out0_valid & ~out0_ready;
      prev_out  = o;
      if (in0_valid & in0_ready) begin
         if (in0_data_field1) eos0_acc = 1'b1;
         else q0.push_back(in0_data_field0);
         i0++;
      end
      if (in1_valid & in1_ready) begin
         if (in1_data_field1) eos1_acc = 1'b1;
         else q1.push_back(in1_data_field0);
         i1++;
      end
      if (out0_valid & out0_ready) begin
         out_log.push_back(o);
         out_cyc.push_back(cyc);
         if (out0_data_field1) begin
            check("single_eos", W1'(eos_out_seen), W1'(1'b0));
            check("eos_last", W1'({eos0_acc, eos1_acc, q0.size() == 0, q1.size() == 0}), W1'(4'hF));
            check("eos_field0", W1'(out0_data_field0), W1'(1'b0));
            eos_out_seen = 1'b1;
            eos_cyc = cyc;
         end else begin
            hit = 1'b0;
            if (q0.size() > 0 && q0[0] == out0_data_field0) begin
               void'(q0.pop_front());
               hit = 1'b1;
            end else if (q1.size() > 0 && q1[0] == out0_data_field0) begin
               void'(q1.pop_front());
               hit = 1'b1;
            end
            check("stream_order", W1'(hit), W1'(1'b1));
         end
      end
      if (outCtrl_valid && !prev_octrl) ctrl_rise_cyc = cyc;
      prev_octrl = outCtrl_valid;
      if (outCtrl_valid & outCtrl_ready) begin
         check("ctrl_after_eos", W1'(eos_out_seen), W1'(1'b1));
         ctrl_cnt++;
         run_active = 1'b0;
      end
      if (inCtrl_valid & inCtrl_ready) begin
         check("start_only_idle", W1'(run_active), W1'(1'b0));
         start_cnt++;
         run_active = 1'b1;
         eos0_acc = 1'b0;
         eos1_acc = 1'b0;
         eos_out_seen = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      drive();
      @(negedge clock);
      observe();
   endtask

   task automatic prep();
      i0 = 0;
      i1 = 0;
      q0.delete();
      q1.delete();
      out_log.delete();
      out_cyc.delete();
   endtask

   task automatic start();
      int s0;
      s0 = start_cnt;
      want_ctrl = 1'b1;
      tick();
      want_ctrl = 1'b0;
      check("start_accepted", W1'(start_cnt - s0), W1'(1));
   endtask

   task automatic run_done(input int max_cyc);
      int c0;
      int n;
      c0 = ctrl_cnt;
      n = 0;
      while (ctrl_cnt == c0 && n < max_cyc) begin
         tick();
         n++;
      end
      check("run_completes", W1'(ctrl_cnt - c0), W1'(1));
   endtask

   initial begin
      int c0, s0, n0, n1;
      reset = 1'b1;
      drive();
      #2 reset = 1'b0;
      #1;
      check("rst_out_valid", W1'(out0_valid), W1'(1'b0));
      check("rst_out_data", {out0_data_field1, out0_data_field0}, '0);
      check("rst_ctrl_valid", W1'(outCtrl_valid), W1'(1'b0));
      check("rst_in_ready", W1'({in0_ready, in1_ready}), W1'(2'b00));
      #20 reset = 1'b1;
      repeat (4) tick();
      check("idle_inctrl_ready", W1'(inCtrl_ready), W1'(1'b1));

      // 5,7,EOS on stream 0 and an empty stream 1
      prep();
      src0.push_back(mk(64'd5)); src0.push_back(mk(64'd7)); src0.push_back(EOS);
      src1.push_back(EOS);
      start();
      run_done(60);
      check("t1_len", W1'(out_log.size()), W1'(3));
      check("t1_e0", out_log[0], mk(64'd5));
      check("t1_e1", out_log[1], mk(64'd7));
      check("t1_e2", out_log[2], EOS);
      check("t1_ctrl_latency", W1'(ctrl_rise_cyc - eos_cyc), W1'(1));
      tick();

      // Both streams continuously valid: strict alternation at full rate
      prep();
      src0.delete(); src1.delete();
      src0.push_back(mk(64'd1)); src0.push_back(mk(64'd2)); src0.push_back(mk(64'd3)); src0.push_back(EOS);
      src1.push_back(mk(64'd10)); src1.push_back(mk(64'd20)); src1.push_back(mk(64'd30)); src1.push_back(EOS);
      start();
      run_done(60);
      check("t2_len", W1'(out_log.size()), W1'(7));
      for (int k = 0; k < 3; k++) begin
         check("t2_even", out_log[2*k], mk(64'(k + 1)));
         check("t2_odd", out_log[2*k+1], mk(64'(10 * (k + 1))));
      end
      check("t2_last", out_log[6], EOS);
      for (int k = 0; k < 5; k++) check("t2_rate", W1'(out_cyc[k+1] - out_cyc[k]), W1'(1));
      tick();

      // Consumer stalls for 3 cycles with 42 buffered
      prep();
      src0.delete(); src1.delete();
      src0.push_back(mk(64'd42)); src0.push_back(EOS);
      src1.push_back(EOS);
      ready_mode = 0;
      start();
      for (int k = 0; k < 10 && !out0_valid; k++) tick();
      for (int k = 0; k < 3; k++) begin
         check("t3_hold", {out0_valid, out0_data_field1, out0_data_field0}, {2'b10, 64'd42});
         check("t3_in_ready", W1'({in0_ready, in1_ready}), W1'(2'b00));
         tick();
      end
      ready_mode = 1;
      run_done(60);
      check("t3_len", W1'(out_log.size()), W1'(2));
      check("t3_e0", out_log[0], mk(64'd42));
      tick();

      // Two empty streams
      prep();
      src0.delete(); src1.delete();
      src0.push_back(EOS); src1.push_back(EOS);
      c0 = ctrl_cnt;
      start();
      run_done(60);
      tick(); tick();
      check("t4_len", W1'(out_log.size()), W1'(1));
      check("t4_eos", out_log[0], EOS);
      check("t4_ctrl_cnt", W1'(ctrl_cnt - c0), W1'(1));
      check("t4_idle", W1'(inCtrl_ready), W1'(1'b1));

      // Reset while 99 is buffered and stream 1 is unfinished
      prep();
      src0.delete(); src1.delete();
      src0.push_back(mk(64'd99));
      ready_mode = 0;
      start();
      for (int k = 0; k < 10 && !out0_valid; k++) tick();
      check("t5_buffered", {out0_valid, out0_data_field1, out0_data_field0}, {2'b10, 64'd99});
      reset = 1'b0;
      #1;
      check("t5_rst_valid", W1'(out0_valid), W1'(1'b0));
      check("t5_rst_data", {out0_data_field1, out0_data_field0}, '0);
      prep();
      src0.delete(); src1.delete();
      prev_hold = 1'b0; run_active = 1'b0;
      eos0_acc = 1'b0; eos1_acc = 1'b0; eos_out_seen = 1'b0;
      ready_mode = 1;
      #13 reset = 1'b1;
      repeat (4) tick();
      check("t5_idle", W1'(inCtrl_ready), W1'(1'b1));
      src0.push_back(EOS); src1.push_back(EOS);
      start();
      run_done(60);
      check("t5_len", W1'(out_log.size()), W1'(1));
      check("t5_eos", out_log[0], EOS);
      tick();

      // Start token during a run is ignored
      prep();
      src0.delete(); src1.delete();
      src0.push_back(mk(64'd11)); src0.push_back(mk(64'd12)); src0.push_back(EOS);
      src1.push_back(mk(64'd21)); src1.push_back(EOS);
      c0 = ctrl_cnt;
      s0 = start_cnt;
      start();
      tick();
      want_ctrl = 1'b1;
      tick();
      check("t6_inctrl_ready_run", W1'(inCtrl_ready), W1'(1'b0));
      tick();
      want_ctrl = 1'b0;
      run_done(60);
      repeat (3) tick();
      check("t6_starts", W1'(start_cnt - s0), W1'(1));
      check("t6_ctrls", W1'(ctrl_cnt - c0), W1'(1));
      check("t6_len", W1'(out_log.size()), W1'(4));

      // Randomized runs against the scoreboard
      rand_valid = 1'b1;
      rand_octrl = 1'b1;
      ready_mode = 2;
      for (int r = 0; r < 20; r++) begin
         prep();
         src0.delete(); src1.delete();
         n0 = $urandom_range(0, 6);
         n1 = $urandom_range(0, 6);
         for (int k = 0; k < n0; k++) src0.push_back(mk(64'h0A00_0000 + 64'(r * 256 + k)));
         for (int k = 0; k < n1; k++) src1.push_back(mk(64'h0B00_0000 + 64'(r * 256 + k)));
         src0.push_back(EOS);
         src1.push_back(EOS);
         start();
         run_done(600);
         check("rnd_len", W1'(out_log.size()), W1'(n0 + n1 + 1));
         if (out_log.size() > 0) check("rnd_last_eos", out_log[out_log.size()-1], EOS);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
